leds_pwm_ctrl: RTL

Memory-mapped LED output controller for the single-cycle RISC-V microcontroller, successor to the plain 16-bit LED latch. It drives `N_LEDS` LEDs with per-LED on/off and a per-LED blink-mode enable. All LEDs share a global PWM brightness and a programmable blink half-period. It sits on the data-memory bus behind the address decoder, which asserts `we` for stores to the LED window and selects the register through `addr`.

---
 rtl/leds_pwm_ctrl_if.sv | 9 +
 rtl/leds_pwm_ctrl.sv | 82 ++++++++
 2 files changed

// File: rtl/leds_pwm_ctrl_if.sv
// leds_pwm_ctrl_if: data-memory store/readback bus between the address decoder and the LED controller
interface leds_pwm_ctrl_if;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  modport master(output we, addr, wr_data, input rd_data);
  modport slave(input we, addr, wr_data, output rd_data);
endinterface

// File: rtl/leds_pwm_ctrl.sv
// leds_pwm_ctrl: memory-mapped LED driver with shared frame-synchronous PWM brightness.
// Per-LED blink mode and the PERIOD register exist only when LEDS_BLINK_EN is defined.
module leds_pwm_ctrl #(
  parameter int N_LEDS   = 16,
  parameter int PWM_BITS = 8,
  parameter int BLINK_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  leds_pwm_ctrl_if.slave    bus,
  output logic [N_LEDS-1:0] leds,
  output logic              blink_phase
);
  logic [N_LEDS-1:0]   value_q, value_d, leds_q, leds_d, mode_w, blink_mask;
  logic [PWM_BITS-1:0] pwm_cnt_q, duty_q, duty_d, duty_act_q;
  logic [BLINK_W-1:0]  period_w;
  logic                frame_end, pwm_on, unused_wr;
  assign frame_end = pwm_cnt_q == '1;
  assign pwm_on    = (duty_act_q == '1) | (pwm_cnt_q < duty_act_q);
  assign unused_wr = ^bus.wr_data;
  always_comb begin
    value_d = (bus.we & (bus.addr == 2'd0)) ? bus.wr_data[N_LEDS-1:0] : value_q;
    duty_d  = (bus.we & (bus.addr == 2'd2)) ? bus.wr_data[PWM_BITS-1:0] : duty_q;
    leds_d  = value_q & {N_LEDS{pwm_on}} & blink_mask;
  end
  // duty_act follows DUTY only at the frame boundary so a frame is never cut short
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q    <= '0;
      duty_q     <= '1;
      duty_act_q <= '1;
      pwm_cnt_q  <= '0;
      leds_q     <= '0;
    end else begin
      value_q    <= value_d;
      duty_q     <= duty_d;
      duty_act_q <= frame_end ? duty_q : duty_act_q;
      pwm_cnt_q  <= pwm_cnt_q + PWM_BITS'(1);
      leds_q     <= leds_d;
    end
  end
`ifdef LEDS_BLINK_EN
  logic [N_LEDS-1:0]  mode_q, mode_d;
  logic [BLINK_W-1:0] period_q, period_d, blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d, wr_period, hold, half_done;
  assign wr_period = bus.we & (bus.addr == 2'd3);
  assign hold      = wr_period | (period_q == '0);
  assign half_done = frame_end & (blink_cnt_q == period_q - BLINK_W'(1));
  always_comb begin
    mode_d      = (bus.we & (bus.addr == 2'd1)) ? bus.wr_data[N_LEDS-1:0] : mode_q;
    period_d    = wr_period ? bus.wr_data[BLINK_W-1:0] : period_q;
    blink_cnt_d = (hold | half_done) ? '0 : frame_end ? blink_cnt_q + BLINK_W'(1) : blink_cnt_q;
    phase_d     = hold ? 1'b1 : half_done ? ~phase_q : phase_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= '0;
      period_q    <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      period_q    <= period_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
  assign mode_w      = mode_q;
  assign period_w    = period_q;
  assign blink_phase = phase_q;
  assign blink_mask  = ~mode_q | {N_LEDS{phase_q}};
`else
  assign mode_w      = '0;
  assign period_w    = '0;
  assign blink_phase = 1'b1;
  assign blink_mask  = '1;
`endif
  assign leds        = leds_q;
  assign bus.rd_data = (bus.addr == 2'd0) ? 32'(value_q) :
                       (bus.addr == 2'd1) ? 32'(mode_w) :
                       (bus.addr == 2'd2) ? 32'(duty_q) : 32'(period_w);
endmodule
